mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- Control-side sequencer for the LC-3 data memory path. It generates the MAR latch enable, the MAR source select and the RAM write enable for LD, ST, LDI and STI.
- It accepts one access request from the main control FSM. It steps the MAR/MDR datapath through the address, indirect and data phases, then returns a one-cycle done pulse and a register-file load strobe.

Parameters:
RAM_LATENCY, 1, cycles from MAR update to valid RAM data_out; legal range 1..15
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > RAM_LATENCY

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request strobe, sampled only in IDLE
op  input  2  access type, captured with start: 00 LD, 01 ST, 10 LDI, 11 STI
busy  output  1  high in every state except IDLE
mar_le  output  1  MAR load enable
mar_control  output  1  MAR source select: 0 = effective address, 1 = memory data (indirect)
we  output  1  RAM write enable
reg_le  output  1  destination register load strobe (loads only)
done  output  1  one-cycle completion pulse

Interface:
- One clock, clk; reset is synchronous and active-low, rst_n.
- All outputs are Moore decodes of the state register only.

Behaviour:
- States:
  - IDLE
  - ADDR: mar_le=1, mar_control=0
  - IWAIT: wait RAM_LATENCY cycles
  - IADDR: mar_le=1, mar_control=1
  - RWAIT: wait RAM_LATENCY cycles
  - WRITE: we=1
  - DONE: done=1; reg_le=1 if the captured op is LD or LDI
- Outputs not listed for a state are 0.
- IDLE behaviour:
  - start=1 → capture op into op_q → ADDR.
  - start=0 → stay in IDLE.
  - start in any other state is ignored; no queuing.
- Transitions by op_q:
  - LD: ADDR→RWAIT→DONE
  - ST: ADDR→WRITE→DONE
  - LDI: ADDR→IWAIT→IADDR→RWAIT→DONE
  - STI: ADDR→IWAIT→IADDR→WRITE→DONE
  - DONE→IDLE unconditionally.
- Wait counter:
  - Loaded with RAM_LATENCY-1 on entry to IWAIT/RWAIT.
  - Exits the state in the cycle it reads 0, so each wait state lasts exactly RAM_LATENCY cycles.
- Latency (start sampled at edge ending cycle T, L = RAM_LATENCY), cycle in which done is high:
  - LD: T+2+L
  - ST: T+3
  - LDI: T+3+2L
  - STI: T+4+L
  - With L=1: LD T+3, ST T+3, LDI T+5, STI T+5.
- Back-to-back: the earliest next accepted start is in the IDLE cycle after DONE.
- Invariants:
  - we is high for exactly one cycle per store and never in the same cycle as mar_le.
  - mar_control=1 only in IADDR.
- Reset:
  - rst_n low at a rising edge → state IDLE, op_q=00, counter=0.
  - All outputs are 0 in the following cycle.
- Reset mid-operation aborts the access:
  - No done or reg_le is produced.
  - No we is produced after the reset edge.
  - A WRITE state coincident with the reset edge still drives we during that cycle; this is permitted.
- rst_n has priority over start in the same edge.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - op encodings OP_LD, OP_ST, OP_LDI, OP_STI
  - state encoding localparams S_IDLE..S_DONE (3 bits)
  - a helper function is_load(op) and is_indirect(op)
- The main control FSM and benches reuse this package.
- No sub-module is required; the wait counter is inline.
- If a second latency counter is needed later, factor it out as lat_counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1, op=01 → busy, mar_le, we, done, reg_le all 0; after release, stays IDLE until start.
- LD, RAM_LATENCY=1: start, op=00 at T → mar_le=1, mar_control=0 at T+1; done=reg_le=1 at T+3; busy=0 at T+4.
  - With a RAM model, EA=0x3000 holding 0xBEEF → DATA=0xBEEF when reg_le=1.
- STI, RAM_LATENCY=1: mem[0x4000]=0x4100 preset, Y=0x1234, EA=0x4000 →
  - mar_le at T+1 (sel 0) and at T+3 (sel 1);
  - we=1 only at T+4; done at T+5, reg_le=0;
  - mem[0x4100]=0x1234 afterwards.
- LDI with RAM_LATENCY=3: mem[0x5000]=0x5100, mem[0x5100]=0x00AA → IADDR at T+5, done at T+9, DATA=0x00AA.
- Start ignored while busy: issue LD, pulse start with op=01 during RWAIT → exactly one done, reg_le=1, no we ever asserted.
- Reset mid-LDI: assert rst_n=0 in IWAIT → next cycle IDLE, no done/reg_le; a fresh ST then completes normally with done at T+3.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: op and state encodings shared by the LC-3 memory access control
package lc3_mem_pkg;
  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_IWAIT = 3'd2,
    S_IADDR = 3'd3,
    S_RWAIT = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;
  function automatic logic is_load(input logic [1:0] op);
    return op == OP_LD || op == OP_LDI;
  endfunction
  function automatic logic is_indirect(input logic [1:0] op);
    return op == OP_LDI || op == OP_STI;
  endfunction
endpackage

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences MAR/RAM control through address, indirect and data phases
module mem_access_seq
  import lc3_mem_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       mar_le,
  output logic       mar_control,
  output logic       we,
  output logic       reg_le,
  output logic       done
);
  state_t state, state_d;
  logic [1:0] op_q;
  logic [CNT_W-1:0] cnt;
  logic wait_entry;
  assign wait_entry = (state_d == S_IWAIT || state_d == S_RWAIT) && state_d != state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_LD;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start) op_q <= op;
      cnt <= wait_entry ? CNT_W'(RAM_LATENCY - 1) : (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  state_d = start ? S_ADDR : S_IDLE;
      S_ADDR:  state_d = is_indirect(op_q) ? S_IWAIT : is_load(op_q) ? S_RWAIT : S_WRITE;
      S_IWAIT: state_d = (cnt == '0) ? S_IADDR : S_IWAIT;
      S_IADDR: state_d = is_load(op_q) ? S_RWAIT : S_WRITE;
      S_RWAIT: state_d = (cnt == '0) ? S_DONE : S_RWAIT;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign busy        = state != S_IDLE;
  assign mar_le      = state == S_ADDR || state == S_IADDR;
  assign mar_control = state == S_IADDR;
  assign we          = state == S_WRITE;
  assign done        = state == S_DONE;
  assign reg_le      = done && is_load(op_q);
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: checks L=1 and L=3 sequencers cycle by cycle against a phase model
module tb_mem_access_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] op = 2'b00;
  logic busy1, mar_le1, mar_control1, we1, reg_le1, done1;
  logic busy3, mar_le3, mar_control3, we3, reg_le3, done3;
  logic [5:0] v1, v3;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_access_seq #(.RAM_LATENCY(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy1), .mar_le(mar_le1),
    .mar_control(mar_control1), .we(we1), .reg_le(reg_le1), .done(done1));
  mem_access_seq #(.RAM_LATENCY(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy3), .mar_le(mar_le3),
    .mar_control(mar_control3), .we(we3), .reg_le(reg_le3), .done(done3));

  assign v1 = {busy1, mar_le1, mar_control1, we1, reg_le1, done1};
  assign v3 = {busy3, mar_le3, mar_control3, we3, reg_le3, done3};

  // Vector order {busy, mar_le, mar_control, we, reg_le, done}; k=1 is the cycle after start is taken.
  function automatic int op_len(input logic [1:0] o, input int l);
    return 1 + (o[1] ? l + 1 : 0) + (!o[0] ? l : 1) + 1;
  endfunction

  function automatic logic [5:0] exp_out(input logic [1:0] o, input int l, input int k);
    int b;
    if (k == 1) return 6'b110000;
    b = 1;
    if (o[1]) begin
      if (k > b && k <= b + l) return 6'b100000;
      if (k == b + l + 1) return 6'b111000;
      b = b + l + 1;
    end
    if (!o[0]) begin
      if (k > b && k <= b + l) return 6'b100000;
      if (k == b + l + 1) return 6'b100011;
    end else begin
      if (k == b + 1) return 6'b100100;
      if (k == b + 2) return 6'b100001;
    end
    return 6'b000000;
  endfunction

  task automatic do_access(input logic [1:0] o, input bit noise, input string name);
    int len1, len3, lmax;
    len1 = op_len(o, 1);
    len3 = op_len(o, 3);
    lmax = (len1 > len3) ? len1 : len3;
    start = 1;
    op = o;
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_before_start busy1=%b busy3=%b exp 0", name, busy1, busy3);
    end
    @(posedge clk) #1;
    start = 0;
    for (int k = 1; k <= lmax; k++) begin
      if (noise && k <= len1 && $urandom_range(1, 0) == 1) begin
        start = 1;
        op = 2'($urandom_range(3, 0));
      end
      @(negedge clk);
      n_cmp++;
      if (v1 !== exp_out(o, 1, k)) begin
        n_err++;
        $display("FAIL %s L1 op=%b k=%0d got %b exp %b", name, o, k, v1, exp_out(o, 1, k));
      end
      n_cmp++;
      if (v3 !== exp_out(o, 3, k)) begin
        n_err++;
        $display("FAIL %s L3 op=%b k=%0d got %b exp %b", name, o, k, v3, exp_out(o, 3, k));
      end
      @(posedge clk) #1;
      start = 0;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    start = 1;
    op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      @(negedge clk);
      n_cmp++;
      if (v1 !== 6'b0 || v3 !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got %b/%b exp 000000", i, v1, v3);
      end
    end
    @(posedge clk) #1;
    rst_n = 1;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      @(negedge clk);
      n_cmp++;
      if (v1 !== 6'b0 || v3 !== 6'b0) begin
        n_err++;
        $display("FAIL reset_release cyc=%0d got %b/%b exp 000000", i, v1, v3);
      end
    end
    @(posedge clk) #1;
  endtask

  task automatic test_directed;
    do_access(2'b00, 0, "ld");
    do_access(2'b01, 0, "st");
    do_access(2'b10, 0, "ldi");
    do_access(2'b11, 0, "sti");
  endtask

  task automatic test_ignore_start;
    do_access(2'b00, 1, "ignore_ld");
    do_access(2'b10, 1, "ignore_ldi");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++) begin
      int gap;
      do_access(2'($urandom_range(3, 0)), $urandom_range(1, 0) == 1, "random");
      gap = $urandom_range(2, 0);
      repeat (gap) @(posedge clk) #1;
    end
  endtask

  task automatic test_reset_mid;
    start = 1;
    op = 2'b10;
    @(posedge clk) #1;
    start = 0;
    @(posedge clk) #1;
    rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if (v1 !== 6'b100000 || v3 !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_mid_iwait got %b/%b exp 100000", v1, v3);
    end
    @(posedge clk) #1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (v1 !== 6'b0 || v3 !== 6'b0) begin
        n_err++;
        $display("FAIL reset_mid_abort cyc=%0d got %b/%b exp 000000", i, v1, v3);
      end
      @(posedge clk) #1;
    end
    do_access(2'b01, 0, "st_after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
